// File: rtl/multicycle_alu_if.sv
// Handshake bundle between the multi-cycle ALU and its producer/consumer.
// The master side issues operations and accepts results; the slave side is the ALU.
`timescale 1ns/1ps
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, aluControl, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, zero, busy
  );

  modport slave (
    input  in_valid, aluControl, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, zero, busy
  );
endinterface

// File: rtl/multicycle_alu.sv
// RV32I-style ALU with registered result and valid/ready handshakes; single-cycle
// ops finish in one edge, mul/mulhu/divu/remu iterate one bit per cycle.
`timescale 1ns/1ps
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter bit MD_EN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  multicycle_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] result;
  logic             zero_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_q;

  logic             accept;
  logic             is_md;
  logic             lt_s;
  logic             lt_u;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quick;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] md_result;

  assign accept = bus.in_valid & in_ready_q;
  // Division by zero never enters BUSY; it is resolved on the single-cycle path.
  assign is_md  = MD_EN && (bus.aluControl[3:2] == 2'b11) &&
                  !(bus.aluControl[1] && (bus.SrcB == '0));
  assign shamt  = bus.SrcB[SHW-1:0];
  assign lt_s   = $signed(bus.SrcA) < $signed(bus.SrcB);
  assign lt_u   = bus.SrcA < bus.SrcB;

  always_comb begin
    quick = '0;
    case (bus.aluControl)
      4'b0000: quick = bus.SrcA + bus.SrcB;
      4'b0001: quick = bus.SrcA - bus.SrcB;
      4'b0010: quick = bus.SrcA & bus.SrcB;
      4'b0011: quick = bus.SrcA | bus.SrcB;
      4'b0100: quick = bus.SrcA ^ bus.SrcB;
      4'b0101: quick = {{(WIDTH-1){1'b0}}, lt_s};
      4'b0110: quick = {{(WIDTH-1){1'b0}}, lt_u};
      4'b0111: quick = bus.SrcA << shamt;
      4'b1000: quick = bus.SrcA >> shamt;
      4'b1001: quick = $signed(bus.SrcA) >>> shamt;
      4'b1110: quick = MD_EN ? '1 : '0;
      4'b1111: quick = MD_EN ? bus.SrcA : '0;
      default: quick = '0;
    endcase
  end

  // hi/lo hold accumulator:multiplier for mul, remainder:quotient for div.
  always_comb begin
    hi_n      = hi;
    lo_n      = lo;
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opa};
    if (md_op[1]) begin
      if (!div_diff[WIDTH]) begin
        hi_n = div_diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_shift[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
    md_result = md_op[0] ? hi_n : lo_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      md_op       <= '0;
      opa         <= '0;
      hi          <= '0;
      lo          <= '0;
      count       <= '0;
      result      <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (is_md) begin
              md_op  <= bus.aluControl[1:0];
              opa    <= bus.SrcB;
              lo     <= bus.SrcA;
              hi     <= '0;
              count  <= '0;
              busy_q <= 1'b1;
              state  <= BUSY;
            end else begin
              result      <= quick;
              zero_q      <= (quick == '0);
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        BUSY: begin
          hi    <= hi_n;
          lo    <= lo_n;
          count <= count + 1'b1;
          if (count == LAST) begin
            result      <= md_result;
            zero_q      <= (md_result == '0);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = result;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;
endmodule
